// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath/memory.
// The master modport is the controller side and the slave modport is the datapath side.
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_write;
  logic             iord;
  logic             ir_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_ctrl;
  logic [1:0]       pc_src;
  logic             pc_en;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en, illegal_op, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en, illegal_op, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared datapath, waits on memory
// ready, and counts retired instructions.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state;
  logic [CNT_W-1:0] retired_q;
  logic [2:0]       funct_ctrl;
  logic             funct_legal;
  logic             retire_now;

  always_comb begin
    funct_ctrl  = 3'b000;
    funct_legal = 1'b1;
    case (bus.funct)
      6'b100000: funct_ctrl = 3'b010;
      6'b100010: funct_ctrl = 3'b110;
      6'b100100: funct_ctrl = 3'b000;
      6'b100101: funct_ctrl = 3'b001;
      6'b101010: funct_ctrl = 3'b111;
      default:   funct_legal = 1'b0;
    endcase
  end

  // A store retires only once memory has accepted the write.
  always_comb begin
    retire_now = 1'b0;
    case (state)
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: retire_now = 1'b1;
      MEMWR:                              retire_now = bus.mem_ready;
      default:                            retire_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      retired_q <= '0;
    end else begin
      if (retire_now) retired_q <= retired_q + 1'b1;
      case (state)
        FETCH:  if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXEC;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: state <= (bus.opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (bus.mem_ready) state <= MEMWB;
        MEMWR:  if (bus.mem_ready) state <= FETCH;
        EXEC:   state <= funct_legal ? ALUWB : FETCH;
        ADDIEX: state <= ADDIWB;
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.retired = retired_q;

  // Moore decode of state; gated by rst_n so every strobe drops the moment reset asserts.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_ctrl   = 3'b000;
    bus.pc_src     = 2'b00;
    bus.pc_en      = 1'b0;
    bus.illegal_op = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.alu_ctrl  = 3'b010;
          bus.ir_write  = bus.mem_ready;
          bus.pc_en     = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_b = 2'b11;
          bus.alu_ctrl  = 3'b010;
          case (bus.opcode)
            OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J: bus.illegal_op = 1'b0;
            default:                                   bus.illegal_op = 1'b1;
          endcase
        end
        MEMADR, ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_ctrl  = 3'b010;
        end
        MEMRD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        MEMWR: begin
          bus.mem_req   = 1'b1;
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
        end
        EXEC: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_ctrl   = funct_ctrl;
          bus.illegal_op = ~funct_legal;
        end
        ALUWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_ctrl  = 3'b110;
          bus.pc_src    = 2'b01;
          bus.pc_en     = bus.zero;
        end
        ADDIWB:  bus.reg_write = 1'b1;
        JUMP: begin
          bus.pc_src = 2'b10;
          bus.pc_en  = 1'b1;
        end
        default: bus.mem_req = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the shared MIPS datapath: PC+4/branch adders, sign extend, RegDst mux, ALU, register file and unified instruction/data memory.
- Decodes opcode/funct from the instruction register and drives per-cycle datapath selects and write strobes.
- Waits on a memory ready handshake and counts retired instructions.
- Sits between the instruction register and all datapath enables.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  Instr[31:26] from the instruction register.
- funct  input  6  Instr[5:0] from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request.
- mem_write  output  1  memory write strobe.
- iord  output  1  address select: 0=PC, 1=ALUOut.
- ir_write  output  1  load instruction register.
- reg_write  output  1  register file write.
- reg_dst  output  1  write register: 0=Instr[20:16], 1=Instr[15:11].
- mem_to_reg  output  1  write data: 0=ALUOut, 1=MDR.
- alu_src_a  output  1  0=PC, 1=rs.
- alu_src_b  output  2  00=rt, 01=4, 10=SignImm, 11=SignImm<<2.
- alu_ctrl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_src  output  2  00=ALU result, 01=ALUOut (branch target), 10=jump target.
- pc_en  output  1  PC load enable.
- illegal_op  output  1  one-cycle pulse on unsupported opcode/funct.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- State register: 4 bits, asynchronous reset to FETCH. While rst_n=0, all outputs are 0 and retired=0.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Outputs are a Moore decode of state, except ir_write/pc_en in FETCH, which are gated by mem_ready. Unlisted outputs are 0 in every state.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010, pc_src=00.
  - If mem_ready=1: ir_write=1, pc_en=1, go to DECODE. Otherwise hold FETCH with ir_write=pc_en=0.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_ctrl=010 (branch target into ALUOut).
  - Next state: opcode 100011 (lw) or 101011 (sw) -> MEMADR; 000000 (R-type) -> EXEC; 000100 (beq) -> BRANCH; 001000 (addi) -> ADDIEX; 000010 (j) -> JUMP.
  - Any other opcode -> FETCH with illegal_op=1 for that cycle; retired unchanged.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=010. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; retire; go to FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1, held high until mem_ready=1; then retire and go to FETCH.
- EXEC:
  - alu_src_a=1, alu_src_b=00.
  - alu_ctrl from funct: 100000 add=010, 100010 sub=110, 100100 and=000, 100101 or=001, 101010 slt=111.
  - Any other funct: illegal_op=1, go to FETCH, no retire. Otherwise go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; retire; go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01, pc_en=zero; retire; go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=010; go to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; retire; go to FETCH.
- JUMP: pc_src=10, pc_en=1; retire; go to FETCH.
- Retire: retired increments by 1 on the clock edge leaving the retiring state. Wraps modulo 2^CNT_W.
- Unused state encodings 12..15 -> FETCH next cycle, all outputs 0, no illegal_op.
- Reset asserted mid-instruction: immediate return to FETCH, strobes drop asynchronously, no partial retire.
- Minimum latencies with mem_ready tied high (cycles): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Test Plan:
- mem_ready=1, R-type add (funct 100000) -> states 0,1,6,7,0; alu_ctrl=010 in EXEC; reg_write=1, reg_dst=1 in ALUWB; retired 0->1.
- lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEMRD -> ir_write pulses exactly once; MEMRD held 3 cycles; mem_to_reg=1 in MEMWB; lw total 5+5=10 cycles.
- beq with zero=1, then with zero=0 -> pc_en=1 / pc_en=0 in BRANCH, pc_src=01 both times, retired increments both times.
- sw with mem_ready low 4 cycles -> mem_write=1 held 5 cycles at iord=1; reg_write never asserted.
- opcode 111111, then R-type funct 000000 -> illegal_op one-cycle pulse each; return to FETCH; retired unchanged.
- rst_n pulled low while in MEMWR -> all outputs 0 asynchronously; after release state=FETCH, mem_req=1, retired=0.
